// File: rtl/timer_pkg.sv
// Shared types and default sizes for the timer_gen counter/prescaler slice.
package timer_pkg;

    typedef enum logic [1:0] {
        MODE_FREE    = 2'b00,
        MODE_RELOAD  = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } timer_mode_e;

    localparam int TIMER_WIDTH_DEF     = 8;
    localparam int TIMER_PSC_WIDTH_DEF = 8;

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler: one tick every psc+1 enabled cycles; clr restarts the count.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int PSC_WIDTH = TIMER_PSC_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic [PSC_WIDTH-1:0] psc,
    output logic                 tick
);

    logic [PSC_WIDTH-1:0] psc_cnt;

    assign tick = en & ~clr & (psc_cnt == psc);

    // A psc lowered below psc_cnt lets the count run on and wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_cnt <= '0;
        end else if (clr) begin
            psc_cnt <= '0;
        end else if (en) begin
            if (psc_cnt == psc) begin
                psc_cnt <= '0;
            end else begin
                psc_cnt <= psc_cnt + PSC_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/timer_gen.sv
// Parametrised up/down timer with prescaler, FREE/RELOAD/ONESHOT modes and sticky status.
// Optional compare output is built when TIMER_CMP_EN is defined.
module timer_gen
    import timer_pkg::*;
#(
    parameter int WIDTH     = TIMER_WIDTH_DEF,
    parameter int PSC_WIDTH = TIMER_PSC_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 updown,
    input  logic [1:0]           mode,
    input  logic                 init_cnt,
    input  logic [WIDTH-1:0]     data_in,
    input  logic [PSC_WIDTH-1:0] psc,
    input  logic                 sts_clr,
    output logic [WIDTH-1:0]     cnt,
    output logic                 over,
    output logic                 under,
    output logic                 ovf_sts,
    output logic                 unf_sts,
    output logic                 running
`ifdef TIMER_CMP_EN
    ,
    input  logic [WIDTH-1:0]     cmp_val,
    output logic                 cmp_match
`endif
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic        tick;
    logic        step;
    timer_mode_e mode_e;

    logic [WIDTH-1:0] cnt_nxt;
    logic             run_nxt;
    logic             ovf_evt;
    logic             unf_evt;

    timer_prescaler #(
        .PSC_WIDTH(PSC_WIDTH)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (init_cnt),
        .psc (psc),
        .tick(tick)
    );

    assign mode_e = timer_mode_e'(mode);
    assign step   = tick & running;

    always_comb begin
        cnt_nxt = cnt;
        run_nxt = running;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        if (init_cnt) begin
            cnt_nxt = data_in;
            run_nxt = 1'b1;
        end else if (step) begin
            if (updown) begin
                if (cnt == MAX) begin
                    ovf_evt = 1'b1;
                    case (mode_e)
                        MODE_RELOAD:  cnt_nxt = data_in;
                        MODE_ONESHOT: run_nxt = 1'b0;
                        default:      cnt_nxt = '0;
                    endcase
                end else begin
                    cnt_nxt = cnt + WIDTH'(1);
                end
            end else begin
                if (cnt == '0) begin
                    unf_evt = 1'b1;
                    case (mode_e)
                        MODE_RELOAD:  cnt_nxt = data_in;
                        MODE_ONESHOT: run_nxt = 1'b0;
                        default:      cnt_nxt = MAX;
                    endcase
                end else begin
                    cnt_nxt = cnt - WIDTH'(1);
                end
            end
        end
    end

    // Event set outranks a simultaneous software clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            running <= 1'b1;
            over    <= 1'b0;
            under   <= 1'b0;
            ovf_sts <= 1'b0;
            unf_sts <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            running <= run_nxt;
            over    <= ovf_evt;
            under   <= unf_evt;
            ovf_sts <= ovf_evt | (ovf_sts & ~sts_clr);
            unf_sts <= unf_evt | (unf_sts & ~sts_clr);
        end
    end

`ifdef TIMER_CMP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_match <= 1'b0;
        end else begin
            cmp_match <= (init_cnt | step) & (cnt_nxt == cmp_val);
        end
    end
`endif

endmodule

// File: tb/tb_timer_gen.sv
// Self-checking bench for timer_gen: directed vector table, corner sequences, random vs model.
module tb_timer_gen;

    localparam int W   = 8;
    localparam int PW  = 8;
    localparam int MAX = 255;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          updown;
    logic [1:0]    mode;
    logic          init_cnt;
    logic [W-1:0]  data_in;
    logic [PW-1:0] psc;
    logic          sts_clr;
    logic [W-1:0]  cnt;
    logic          over;
    logic          under;
    logic          ovf_sts;
    logic          unf_sts;
    logic          running;
`ifdef TIMER_CMP_EN
    logic [W-1:0]  cmp_val;
    logic          cmp_match;
`endif

    timer_gen #(.WIDTH(W), .PSC_WIDTH(PW)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .updown  (updown),
        .mode    (mode),
        .init_cnt(init_cnt),
        .data_in (data_in),
        .psc     (psc),
        .sts_clr (sts_clr),
        .cnt     (cnt),
        .over    (over),
        .under   (under),
        .ovf_sts (ovf_sts),
        .unf_sts (unf_sts),
        .running (running)
`ifdef TIMER_CMP_EN
        ,
        .cmp_val  (cmp_val),
        .cmp_match(cmp_match)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model: plain integers following the counting rules.
    int m_cnt, m_pc;
    bit m_over, m_under, m_ovf, m_unf, m_run, m_cmp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_pc = 0; m_over = 0; m_under = 0;
        m_ovf = 0; m_unf = 0; m_run = 1; m_cmp = 0;
    endtask

    task automatic model_step();
        bit tk;
        bit moved;
        tk = en && !init_cnt && (m_pc == int'(psc));
        m_over = 0; m_under = 0; moved = 0;
        if (init_cnt) m_pc = 0;
        else if (en) m_pc = tk ? 0 : (m_pc + 1) % (1 << PW);
        if (init_cnt) begin
            m_cnt = int'(data_in); m_run = 1; moved = 1;
        end else if (tk && m_run) begin
            moved = 1;
            if (updown) begin
                if (m_cnt == MAX) begin
                    m_over = 1;
                    if (mode == 2'd1) m_cnt = int'(data_in);
                    else if (mode == 2'd2) m_run = 0;
                    else m_cnt = 0;
                end else m_cnt = m_cnt + 1;
            end else begin
                if (m_cnt == 0) begin
                    m_under = 1;
                    if (mode == 2'd1) m_cnt = int'(data_in);
                    else if (mode == 2'd2) m_run = 0;
                    else m_cnt = MAX;
                end else m_cnt = m_cnt - 1;
            end
        end
        m_ovf = m_over | (m_ovf & !sts_clr);
        m_unf = m_under | (m_unf & !sts_clr);
`ifdef TIMER_CMP_EN
        m_cmp = moved && (m_cnt == int'(cmp_val));
`else
        m_cmp = moved && 1'b0;
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".cnt"},     32'(cnt),     32'(m_cnt));
        chk({tag, ".over"},    32'(over),    32'(m_over));
        chk({tag, ".under"},   32'(under),   32'(m_under));
        chk({tag, ".ovf_sts"}, 32'(ovf_sts), 32'(m_ovf));
        chk({tag, ".unf_sts"}, 32'(unf_sts), 32'(m_unf));
        chk({tag, ".running"}, 32'(running), 32'(m_run));
`ifdef TIMER_CMP_EN
        chk({tag, ".cmp_match"}, 32'(cmp_match), 32'(m_cmp));
`endif
    endtask

    typedef struct {
        logic       en, up, init, clr;
        logic [1:0] mode;
        logic [7:0] data, psc;
        logic [7:0] cnt;
        logic       over, under, ovf, unf, run;
    } vec_t;

    vec_t vt[18];

    initial begin
        int seen;
        int first_at;
        bool_dummy: begin end

        rst = 1'b1; en = 0; updown = 1; mode = 0; init_cnt = 0;
        data_in = 0; psc = 0; sts_clr = 0;
`ifdef TIMER_CMP_EN
        cmp_val = 8'hFF;
`endif
        model_reset();
        #12;
        check_model("reset");
        rst = 1'b0;

        //          en up in clr mode  data   psc  | cnt  ov un ovf unf run
        vt[0]  = '{1, 1, 1, 0, 2'd0, 8'd254, 8'd0, 8'd254, 0, 0, 0, 0, 1};
        vt[1]  = '{1, 1, 0, 0, 2'd0, 8'd0,   8'd0, 8'd255, 0, 0, 0, 0, 1};
        vt[2]  = '{1, 1, 0, 0, 2'd0, 8'd0,   8'd0, 8'd0,   1, 0, 1, 0, 1};
        vt[3]  = '{1, 1, 0, 0, 2'd0, 8'd0,   8'd0, 8'd1,   0, 0, 1, 0, 1};
        vt[4]  = '{1, 0, 0, 0, 2'd0, 8'd0,   8'd0, 8'd0,   0, 0, 1, 0, 1};
        vt[5]  = '{1, 0, 0, 0, 2'd0, 8'd0,   8'd0, 8'd255, 0, 1, 1, 1, 1};
        vt[6]  = '{0, 0, 0, 1, 2'd0, 8'd0,   8'd0, 8'd255, 0, 0, 0, 0, 1};
        vt[7]  = '{0, 0, 1, 0, 2'd2, 8'd0,   8'd0, 8'd0,   0, 0, 0, 0, 1};
        vt[8]  = '{1, 0, 0, 0, 2'd2, 8'd0,   8'd0, 8'd0,   0, 1, 0, 1, 0};
        vt[9]  = '{1, 0, 0, 0, 2'd2, 8'd0,   8'd0, 8'd0,   0, 0, 0, 1, 0};
        vt[10] = '{0, 0, 1, 0, 2'd2, 8'd7,   8'd0, 8'd7,   0, 0, 0, 1, 1};
        vt[11] = '{1, 1, 1, 0, 2'd0, 8'd255, 8'd0, 8'd255, 0, 0, 0, 1, 1};
        vt[12] = '{1, 1, 0, 1, 2'd0, 8'd0,   8'd0, 8'd0,   1, 0, 1, 0, 1};
        vt[13] = '{0, 1, 0, 1, 2'd0, 8'd0,   8'd0, 8'd0,   0, 0, 0, 0, 1};
        vt[14] = '{0, 1, 1, 0, 2'd1, 8'd255, 8'd0, 8'd255, 0, 0, 0, 0, 1};
        vt[15] = '{1, 1, 0, 0, 2'd1, 8'd9,   8'd0, 8'd9,   1, 0, 1, 0, 1};
        vt[16] = '{1, 0, 1, 0, 2'd3, 8'd0,   8'd0, 8'd0,   0, 0, 1, 0, 1};
        vt[17] = '{1, 0, 0, 0, 2'd3, 8'd0,   8'd0, 8'd255, 0, 1, 1, 1, 1};

        for (int i = 0; i < 18; i++) begin
            en = vt[i].en; updown = vt[i].up; init_cnt = vt[i].init; sts_clr = vt[i].clr;
            mode = vt[i].mode; data_in = vt[i].data; psc = vt[i].psc;
            cycle();
            chk($sformatf("vec%0d.cnt", i),   32'(cnt),     32'(vt[i].cnt));
            chk($sformatf("vec%0d.over", i),  32'(over),    32'(vt[i].over));
            chk($sformatf("vec%0d.under", i), 32'(under),   32'(vt[i].under));
            chk($sformatf("vec%0d.ovf", i),   32'(ovf_sts), 32'(vt[i].ovf));
            chk($sformatf("vec%0d.unf", i),   32'(unf_sts), 32'(vt[i].unf));
            chk($sformatf("vec%0d.run", i),   32'(running), 32'(vt[i].run));
        end
        sts_clr = 0;

        // FREE up from 100: overflow 156 ticks after load.
        en = 1; updown = 1; mode = 2'd0; psc = 0; data_in = 100; init_cnt = 1;
        cycle();
        init_cnt = 0;
        first_at = -1;
        for (int i = 1; i <= 400 && first_at < 0; i++) begin
            cycle();
            if (over) first_at = i;
        end
        chk("free_over_ticks", 32'(first_at), 32'd156);
        chk("free_over_cnt", 32'(cnt), 32'd0);
        chk("free_over_ovf", 32'(ovf_sts), 32'd1);

        // RELOAD down from 20: underflow every 21 ticks, reloading 20.
        mode = 2'd1; updown = 0; data_in = 20; init_cnt = 1;
        cycle();
        init_cnt = 0;
        seen = 0; first_at = -1;
        for (int i = 1; i <= 63; i++) begin
            cycle();
            if (under) begin
                seen++;
                if (first_at < 0) first_at = i;
                chk("reload_cnt", 32'(cnt), 32'd20);
                chk("reload_period", 32'(i % 21), 32'd0);
            end
        end
        chk("reload_first", 32'(first_at), 32'd21);
        chk("reload_count", 32'(seen), 32'd3);

        // ONESHOT up from 250: expires after 6 ticks, then stays silent.
        mode = 2'd2; updown = 1; data_in = 250; init_cnt = 1;
        cycle();
        init_cnt = 0;
        first_at = -1;
        for (int i = 1; i <= 20 && first_at < 0; i++) begin
            cycle();
            if (over) first_at = i;
        end
        chk("oneshot_ticks", 32'(first_at), 32'd6);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (over || under) seen++;
        end
        chk("oneshot_silent", 32'(seen), 32'd0);
        chk("oneshot_cnt", 32'(cnt), 32'd255);
        chk("oneshot_run", 32'(running), 32'd0);
        init_cnt = 1; data_in = 3;
        cycle();
        init_cnt = 0;
        chk("oneshot_rearm", 32'(running), 32'd1);

        // psc=3 with en toggling: one tick per 8 clocks; en low freezes everything.
        mode = 2'd0; updown = 1; psc = 3; data_in = 0; init_cnt = 1;
        cycle();
        init_cnt = 0;
        for (int i = 1; i <= 64; i++) begin
            en = i[0];
            cycle();
        end
        chk("psc_toggle_cnt", 32'(cnt), 32'd8);
        en = 0;
        for (int i = 0; i < 20; i++) cycle();
        chk("psc_hold_cnt", 32'(cnt), 32'd8);
        en = 1;
        for (int i = 0; i < 3; i++) cycle();
        chk("psc_frozen_pc", 32'(cnt), 32'd8);
        cycle();
        chk("psc_resume", 32'(cnt), 32'd9);

        // Asynchronous reset mid-count (cnt=77, psc_cnt=2).
        updown = 1; mode = 2'd0; data_in = 77; init_cnt = 1;
        cycle();
        init_cnt = 0;
        cycle();
        cycle();
        chk("pre_rst_cnt", 32'(cnt), 32'd77);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_model("async_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("post_rst_pc", 32'(cnt), 32'd0);
        cycle();
        chk("post_rst_tick", 32'(cnt), 32'd1);

`ifdef TIMER_CMP_EN
        // Compare: cmp_val=5 from 0 up pulses right after tick 5.
        psc = 0; cmp_val = 5; data_in = 0; init_cnt = 1;
        cycle();
        init_cnt = 0;
        first_at = -1;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (cmp_match && first_at < 0) first_at = i;
        end
        chk("cmp_tick", 32'(first_at), 32'd5);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) updown = $urandom_range(0, 1);
            if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
            init_cnt = ($urandom_range(0, 63) == 0);
            data_in  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255))
                                                   : 8'($urandom_range(0, 6));
            if ($urandom_range(0, 99) == 0) psc = 8'($urandom_range(0, 3));
            sts_clr  = ($urandom_range(0, 19) == 0);
`ifdef TIMER_CMP_EN
            if ($urandom_range(0, 49) == 0) cmp_val = 8'($urandom);
`endif
            cycle();
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
